// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register,
// plus cycle/stall/flush performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] JrTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] IM_Addr,
  input  logic [31:0] IM_Data,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC_plus4,
  output logic        IFID_Valid,
  output logic [31:0] CycleCount,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [1:0]  pcsrc_eff;
  logic        unused_low_bits;

  // Targets are word aligned, so the low bits of the redirect inputs never reach the PC.
  assign unused_low_bits = ^{JrTarget[1:0], BranchTarget[1:0]};

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pc4_q[31:28], instr_q[25:0], 2'b00};
  // A bubble in decode carries no instruction, so it must never redirect fetch.
  assign pcsrc_eff   = valid_q ? PCSrc : 2'b00;

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (BranchTaken) begin
      pc_d        = {BranchTarget[31:2], 2'b00};
      instr_d     = 32'h0;
      pc4_d       = 32'h0;
      valid_d     = 1'b0;
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (Stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      case (pcsrc_eff)
        2'b01: begin
          pc_d        = jump_target;
          instr_d     = 32'h0;
          pc4_d       = 32'h0;
          valid_d     = 1'b0;
          flush_cnt_d = flush_cnt_q + 32'd1;
        end
        2'b10: begin
          pc_d        = {JrTarget[31:2], 2'b00};
          instr_d     = 32'h0;
          pc4_d       = 32'h0;
          valid_d     = 1'b0;
          flush_cnt_d = flush_cnt_q + 32'd1;
        end
        default: begin
          pc_d    = pc_plus4;
          instr_d = IM_Data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      cycle_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign IM_Addr          = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PC_plus4    = pc4_q;
  assign IFID_Valid       = valid_q;
  assign CycleCount       = cycle_cnt_q;
  assign StallCount       = stall_cnt_q;
  assign FlushCount       = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, j/jr redirects, stall hold,
// branch priority, PC wrap and reset discarding pending state.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic [1:0]  PCSrc;
  logic [31:0] JrTarget;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Data;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PC_plus4;
  logic        IFID_Valid;
  logic [31:0] CycleCount;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .Stall            (Stall),
    .PCSrc            (PCSrc),
    .JrTarget         (JrTarget),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .IM_Addr          (IM_Addr),
    .IM_Data          (IM_Data),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PC_plus4    (IFID_PC_plus4),
    .IFID_Valid       (IFID_Valid),
    .CycleCount       (CycleCount),
    .StallCount       (StallCount),
    .FlushCount       (FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall        = 1'b0;
    PCSrc        = 2'b00;
    JrTarget     = 32'h0;
    BranchTaken  = 1'b0;
    BranchTarget = 32'h0;
    IM_Data      = 32'h0;
  endtask

  // Called just after a rising edge; reset pulse stays clear of the next edge.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_regs: got pc=%h ins=%h pc4=%h v=%b expected 0/0/0/0",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid);
    end
    step();
    checks++;
    if ({CycleCount, StallCount, FlushCount, IM_Addr} !== 128'h0) begin
      errors++;
      $display("FAIL reset_hold: got cyc=%0d stl=%0d fl=%0d pc=%h expected all 0",
               CycleCount, StallCount, FlushCount, IM_Addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    IM_Data = 32'hAAAA0001;
    checks++;
    if (IM_Addr !== 32'h0) begin
      errors++; $display("FAIL seq_pc0: got %h expected 00000000", IM_Addr);
    end
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid} !== {32'h4, 32'hAAAA0001, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL seq_c1: got pc=%h ins=%h pc4=%h v=%b expected 4/AAAA0001/4/1",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid);
    end
    IM_Data = 32'hBBBB0002;
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid} !== {32'h8, 32'hBBBB0002, 32'h8, 1'b1}) begin
      errors++;
      $display("FAIL seq_c2: got pc=%h ins=%h pc4=%h v=%b expected 8/BBBB0002/8/1",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid);
    end
    IM_Data = 32'hCCCC0003;
    step();
    checks++;
    if ({IM_Addr, CycleCount, FlushCount, StallCount} !== {32'hC, 32'd3, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL seq_c3: got pc=%h cyc=%0d fl=%0d stl=%0d expected C/3/0/0",
               IM_Addr, CycleCount, FlushCount, StallCount);
    end
  endtask

  task automatic test_jump();
    do_reset();
    IM_Data = 32'h11111111;
    step();
    IM_Data = 32'h08000010;
    step();
    checks++;
    if ({IFID_Instruction, IFID_PC_plus4, IFID_Valid} !== {32'h08000010, 32'h8, 1'b1}) begin
      errors++;
      $display("FAIL jump_setup: got ins=%h pc4=%h v=%b expected 08000010/8/1",
               IFID_Instruction, IFID_PC_plus4, IFID_Valid);
    end
    PCSrc   = 2'b01;
    IM_Data = 32'hDEADBEEF;
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, FlushCount, CycleCount}
        !== {32'h40, 32'h0, 32'h0, 1'b0, 32'd1, 32'd3}) begin
      errors++;
      $display("FAIL jump: got pc=%h ins=%h pc4=%h v=%b fl=%0d cyc=%0d expected 40/0/0/0/1/3",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, FlushCount, CycleCount);
    end
    PCSrc = 2'b00;
  endtask

  task automatic test_jr();
    do_reset();
    IM_Data = 32'h22222222;
    step();
    PCSrc    = 2'b10;
    JrTarget = 32'h00000123;
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, FlushCount}
        !== {32'h120, 32'h0, 32'h0, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL jr: got pc=%h ins=%h pc4=%h v=%b fl=%0d expected 120/0/0/0/1",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, FlushCount);
    end
    // Decode holds a bubble now, so a j request must be ignored.
    PCSrc   = 2'b01;
    IM_Data = 32'h33333333;
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, FlushCount}
        !== {32'h124, 32'h33333333, 32'h124, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL bubble_ignore: got pc=%h ins=%h pc4=%h v=%b fl=%0d expected 124/33333333/124/1/1",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, FlushCount);
    end
    PCSrc = 2'b00;
  endtask

  task automatic test_stall();
    do_reset();
    IM_Data = 32'h44444444;
    step();
    Stall    = 1'b1;
    PCSrc    = 2'b10;
    JrTarget = 32'h00000300;
    IM_Data  = 32'h55555555;
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid} !== {32'h4, 32'h44444444, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL stall_c1: got pc=%h ins=%h pc4=%h v=%b expected 4/44444444/4/1",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid);
    end
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, StallCount, FlushCount}
        !== {32'h4, 32'h44444444, 32'h4, 1'b1, 32'd2, 32'd0}) begin
      errors++;
      $display("FAIL stall_c2: got pc=%h ins=%h pc4=%h v=%b stl=%0d fl=%0d expected 4/44444444/4/1/2/0",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, StallCount, FlushCount);
    end
    Stall = 1'b0;
    step();
    checks++;
    if ({IM_Addr, IFID_Valid, StallCount, FlushCount} !== {32'h300, 1'b0, 32'd2, 32'd1}) begin
      errors++;
      $display("FAIL stall_release_jr: got pc=%h v=%b stl=%0d fl=%0d expected 300/0/2/1",
               IM_Addr, IFID_Valid, StallCount, FlushCount);
    end
    // Stall over a bubble keeps the bubble.
    Stall = 1'b1;
    PCSrc = 2'b00;
    step();
    checks++;
    if ({IM_Addr, IFID_Valid, StallCount, CycleCount} !== {32'h300, 1'b0, 32'd3, 32'd5}) begin
      errors++;
      $display("FAIL stall_bubble: got pc=%h v=%b stl=%0d cyc=%0d expected 300/0/3/5",
               IM_Addr, IFID_Valid, StallCount, CycleCount);
    end
    Stall = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    IM_Data = 32'h08000010;
    step();
    Stall        = 1'b1;
    PCSrc        = 2'b01;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h00000203;
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, StallCount, FlushCount, CycleCount}
        !== {32'h200, 32'h0, 32'h0, 1'b0, 32'd0, 32'd1, 32'd2}) begin
      errors++;
      $display("FAIL branch_priority: got pc=%h ins=%h pc4=%h v=%b stl=%0d fl=%0d cyc=%0d expected 200/0/0/0/0/1/2",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, StallCount, FlushCount, CycleCount);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    BranchTaken  = 1'b1;
    BranchTarget = 32'hFFFFFFFF;
    step();
    checks++;
    if (IM_Addr !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL wrap_setup: got %h expected FFFFFFFC", IM_Addr);
    end
    BranchTaken = 1'b0;
    IM_Data     = 32'h66666666;
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid} !== {32'h0, 32'h66666666, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL wrap: got pc=%h ins=%h pc4=%h v=%b expected 0/66666666/0/1",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    IM_Data = 32'h77777777;
    step();
    Stall    = 1'b1;
    PCSrc    = 2'b10;
    JrTarget = 32'h00000500;
    step();
    reset = 1'b1;
    #2;
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_Valid, CycleCount, StallCount}
        !== {32'h0, 32'h0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_async: got pc=%h ins=%h v=%b cyc=%0d stl=%0d expected 0/0/0/0/0",
               IM_Addr, IFID_Instruction, IFID_Valid, CycleCount, StallCount);
    end
    idle_inputs();
    IM_Data = 32'h88888888;
    reset   = 1'b0;
    step();
    checks++;
    if ({IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, CycleCount}
        !== {32'h4, 32'h88888888, 32'h4, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL reset_refetch: got pc=%h ins=%h pc4=%h v=%b cyc=%0d expected 4/88888888/4/1/1",
               IM_Addr, IFID_Instruction, IFID_PC_plus4, IFID_Valid, CycleCount);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_jump();
    test_jr();
    test_stall();
    test_branch();
    test_wrap();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Stall  input  1  load-use hold request from the hazard unit.
REQ-005 SHALL have port PCSrc  input  2  next-PC select from ID decode: 00 sequential, 01 j/jal, 10 jr/jalr, 11 treated as 00.
REQ-006 SHALL have port JrTarget  input  32  forwarded rs value for jr/jalr.
REQ-007 SHALL have port BranchTaken  input  1  branch resolved taken in EX.
REQ-008 SHALL have port BranchTarget  input  32  EX branch target.
REQ-009 SHALL have port IM_Addr  output  32  instruction memory address, equal to current PC.
REQ-010 SHALL have port IM_Data  input  32  instruction word for IM_Addr, valid in the same cycle.
REQ-011 SHALL have port IFID_Instruction  output  32  registered instruction feeding ID decode.
REQ-012 SHALL have port IFID_PC_plus4  output  32  registered PC+4 of that instruction.
REQ-013 SHALL have port IFID_Valid  output  1  0 marks a bubble in IF/ID.
REQ-014 SHALL have ports CycleCount, StallCount, FlushCount  output  32 each  performance counters.

Function
REQ-015 SHALL hold a 32-bit PC register and drive IM_Addr = PC combinationally.
REQ-016 SHALL compute jump target = {IFID_PC_plus4[31:28], IFID_Instruction[25:0], 2'b00}.
REQ-017 SHALL force bits [1:0] of every loaded PC to 2'b00, including JrTarget and BranchTarget.
REQ-018 SHALL select next PC by priority: BranchTaken -> BranchTarget; else Stall -> hold PC; else PCSrc 01 -> jump target; PCSrc 10 -> JrTarget; otherwise PC+4.
REQ-019 SHALL, when BranchTaken=1, load bubble into IF/ID (Instruction 32'h0, PC_plus4 32'h0, Valid 0), regardless of Stall and PCSrc.
REQ-020 SHALL, when Stall=1 and BranchTaken=0, hold IF/ID unchanged, including Valid, and ignore PCSrc.
REQ-021 SHALL, when PCSrc is 01 or 10 with Stall=0 and BranchTaken=0, load bubble into IF/ID, squashing the fetched slot.
REQ-022 SHALL otherwise load IF/ID with IM_Data, PC+4, Valid=1.
REQ-023 SHALL ignore PCSrc while IFID_Valid=0, so decode of a bubble never redirects.
REQ-024 SHALL compute PC+4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-025 SHALL increment CycleCount every cycle out of reset.
REQ-026 SHALL increment StallCount in cycles where Stall=1 and BranchTaken=0.
REQ-027 SHALL increment FlushCount in each cycle a bubble is loaded per REQ-019 or REQ-021.
REQ-028 SHALL wrap all counters modulo 2^32 with no saturation.
REQ-029 SHALL produce one-cycle latency from PC update to IF/ID load; no other registers.

Reset
REQ-030 SHALL, while reset=1, asynchronously force PC=RESET_PC, IFID_Instruction=0, IFID_PC_plus4=0, IFID_Valid=0, and all counters=0.
REQ-031 SHALL, on the first rising edge after reset deasserts, fetch from RESET_PC; reset asserted mid-stall or mid-redirect discards all pending state.

Verification
REQ-032 SHALL cover reset then 3 free-running cycles with IM_Data = A,B,C -> IM_Addr 0,4,8,C; IFID = (A,4,1),(B,8,1); CycleCount=3.
REQ-033 SHALL cover j with IFID_Instruction=32'h08000010, IFID_PC_plus4=32'h00000008 -> next PC 32'h00000040, IF/ID bubble, FlushCount+1.
REQ-034 SHALL cover jr with JrTarget=32'h00000123 -> PC 32'h00000120, IF/ID bubble.
REQ-035 SHALL cover Stall=1 for 2 cycles with PCSrc=10 -> PC and IF/ID unchanged, StallCount+2, then jr taken on release.
REQ-036 SHALL cover BranchTaken=1, BranchTarget=32'h00000200, with Stall=1 and PCSrc=01 -> PC 32'h00000200, IF/ID bubble, StallCount unchanged.
REQ-037 SHALL cover PC=32'hFFFFFFFC sequential -> PC 32'h00000000, IFID_PC_plus4 32'h00000000 with Valid=1.
